truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
- Controller that drives a 3-input combinational gate under test through all 8 input rows, waits a settle time, samples the gate output, and assembles an 8-bit truth-table word.
- Uses the same 8-bit hex truth-table identifier as the gate modules, e.g. 0xA3, and compares the captured word against an expected word.
- Sits between a test/config host and one gate instance. Used for in-system gate characterisation and self-check.

Parameters:
- SETTLE_CYCLES, 4, clock cycles to wait after applying a row before the first sample (legal 1..255).
- NUM_SAMPLES, 2, consecutive cycles sampled per row; all samples must agree (legal 1..15).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- expected  input  8  expected truth-table word; latched when start is accepted.
- gate_in1  output  1  gate input in1 (MSB of row index).
- gate_in2  output  1  gate input in2.
- gate_in3  output  1  gate input in3 (LSB of row index).
- gate_out  input  1  gate output.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse when the sweep completes.
- captured  output  8  assembled truth-table word.
- mismatch  output  8  captured XOR latched expected.
- pass  output  1  high when mismatch==0 and unstable==0; valid from done until the next start.
- unstable  output  8  per-row flag: samples disagreed.

Behaviour:
- Bit mapping: row r = {in1,in2,in3} maps to word bit [7-r]. Row 000 is the MSB and row 111 is the LSB. With this mapping, gate 0xA3 yields captured=8'hA3.
- Reset: clock and reset are as stated in the interface (one clock, synchronous active-high rst). While rst is high, or on the edge it is sampled high:
  - FSM goes to IDLE.
  - gate_in1/2/3=0, busy=0, done=0, captured=0, mismatch=0, pass=0, unstable=0.
  - Row index, settle counter and sample counter are cleared.
  - Reset mid-sweep aborts immediately. No done pulse. Partial results are discarded.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, NEXT, DONE.
  - IDLE: gate_in*=0. On start=1: latch expected, set row=0, clear captured and unstable, go to APPLY. Results from the previous sweep stay visible until this point.
  - APPLY (1 cycle): drive gate_in = row, load settle counter = SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE (SETTLE_CYCLES cycles): count down; at 0 go to SAMPLE with sample counter = 0.
  - SAMPLE (NUM_SAMPLES cycles):
    - First cycle: record gate_out as the row value.
    - Each later cycle: if gate_out differs from the recorded value, set unstable[7-row].
    - After the last sample, write the recorded value to captured[7-row].
    - If row==7 go to DONE, else go to NEXT.
  - NEXT: row+1, go to APPLY. This state is folded into the last SAMPLE cycle, so it costs 0 cycles.
  - DONE (1 cycle): done=1, busy=1, mismatch=captured^expected_latched, pass updated. Then go to IDLE.
- Timing:
  - gate_in* hold the row value through APPLY, SETTLE and SAMPLE, and change only on entry to APPLY of the next row.
  - Per-row cost is 1+SETTLE_CYCLES+NUM_SAMPLES cycles.
  - With defaults: 7 cycles per row, 56 cycles of row activity, done asserted on cycle 57 after the start-accept edge.
- Boundary and handshake rules:
  - start while busy is ignored; no queueing.
  - start held high continuously re-triggers on the cycle after DONE returns to IDLE.
  - The row counter is 3 bits and never wraps within a sweep; termination is on row==7 at the end of SAMPLE.
  - The settle counter is 8 bits; the sample counter is 4 bits.
  - expected changing mid-sweep has no effect.
  - gate_out is assumed synchronous to clk; the sequencer provides no synchroniser.

Decomposition:
- Shared package truth_table_pkg:
  - State enum (IDLE, APPLY, SETTLE, SAMPLE, DONE).
  - Constant NUM_ROWS=8.
  - Function row_to_bit(r)=7-r.
- The FSM, counters and result registers live in one module.
- One natural sub-module, tt_sample_checker: NUM_SAMPLES capture and agreement logic. It takes start_sample, the sample enable and gate_out, and outputs value, stable and last.

Test Plan:
- Gate model 0xA3, expected=8'hA3, defaults, pulse start → done on cycle 57; captured=8'hA3, mismatch=8'h00, unstable=8'h00, pass=1; gate_in sequence 000..111, each held 7 cycles.
- Same gate, expected=8'hA2 → captured=8'hA3, mismatch=8'h01, pass=0.
- Gate toggles gate_out on the second sample of row 011 → unstable=8'h10, pass=0; captured bit 4 equals the first-sample value.
- rst asserted on cycle 20 of a sweep → next cycle: busy=0, all outputs 0; no done pulse; a new start then completes normally in 57 cycles.
- start re-pulsed on cycles 5 and 30 of a sweep → ignored; exactly one done at cycle 57.
- SETTLE_CYCLES=1, NUM_SAMPLES=1, gate 0x00, expected=8'hFF → done on cycle 25; captured=8'h00, mismatch=8'hFF, pass=0.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sequencer and its sample checker.
package truth_table_pkg;

    localparam int unsigned NUM_ROWS = 8;
    localparam int unsigned ROW_W    = 3;
    localparam int unsigned WORD_W   = 8;
    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned SAMPLE_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } tt_state_e;

    // Row 000 lands in the MSB of the truth-table word, row 111 in the LSB.
    function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] r);
        return ROW_W'(NUM_ROWS - 1) - r;
    endfunction

endpackage

// File: rtl/tt_sample_checker.sv
// Multi-sample capture for one row: records the first sample and flags any later disagreement.
module tt_sample_checker
    import truth_table_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start_sample,
    input  logic i_sample_en,
    input  logic i_gate_out,
    output logic o_value_c,
    output logic o_stable_c,
    output logic o_last_c
);

    logic [SAMPLE_W-1:0] r_cnt;
    logic                r_value;
    logic                w_first;

    assign w_first = (r_cnt == '0);

    // start_sample rewinds the count so the next enabled cycle is the first sample.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_start_sample) begin
            r_cnt <= '0;
        end else if (i_sample_en) begin
            r_cnt <= r_cnt + SAMPLE_W'(1);
        end

        if (i_rst) begin
            r_value <= 1'b0;
        end else if (i_sample_en && w_first) begin
            r_value <= i_gate_out;
        end
    end

    assign o_value_c  = w_first ? i_gate_out : r_value;
    assign o_stable_c = w_first || (i_gate_out == r_value);
    assign o_last_c   = (r_cnt == SAMPLE_W'(NUM_SAMPLES - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps a 3-input gate through all rows, samples its output and builds/compares the truth-table word.
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned NUM_SAMPLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  expected,
    output logic        gate_in1,
    output logic        gate_in2,
    output logic        gate_in3,
    input  logic        gate_out,
    output logic        busy,
    output logic        done,
    output logic [7:0]  captured,
    output logic [7:0]  mismatch,
    output logic        pass,
    output logic [7:0]  unstable
);

    tt_state_e           r_state,    w_state_nxt;
    logic [ROW_W-1:0]    r_row,      w_row_nxt;
    logic [ROW_W-1:0]    r_gate_in,  w_gate_in_nxt;
    logic [SETTLE_W-1:0] r_settle,   w_settle_nxt;
    logic [WORD_W-1:0]   r_expected, w_expected_nxt;
    logic [WORD_W-1:0]   r_captured, w_captured_nxt;
    logic [WORD_W-1:0]   r_unstable, w_unstable_nxt;
    logic [WORD_W-1:0]   r_mismatch, w_mismatch_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_done,     w_done_nxt;
    logic                r_pass,     w_pass_nxt;

    logic                w_start_sample;
    logic                w_sample_en;
    logic                w_value;
    logic                w_stable;
    logic                w_last;
    logic [ROW_W-1:0]    w_bit;

    assign w_bit = row_to_bit(r_row);

    tt_sample_checker #(
        .NUM_SAMPLES (NUM_SAMPLES)
    ) u_sample_checker (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start_sample (w_start_sample),
        .i_sample_en    (w_sample_en),
        .i_gate_out     (gate_out),
        .o_value_c      (w_value),
        .o_stable_c     (w_stable),
        .o_last_c       (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_gate_in  <= '0;
            r_settle   <= '0;
            r_expected <= '0;
            r_captured <= '0;
            r_unstable <= '0;
            r_mismatch <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_gate_in  <= w_gate_in_nxt;
            r_settle   <= w_settle_nxt;
            r_expected <= w_expected_nxt;
            r_captured <= w_captured_nxt;
            r_unstable <= w_unstable_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
        end
    end

    // Next row is launched from the last SAMPLE cycle, so NEXT costs no cycle of its own.
    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_gate_in_nxt  = r_gate_in;
        w_settle_nxt   = r_settle;
        w_expected_nxt = r_expected;
        w_captured_nxt = r_captured;
        w_unstable_nxt = r_unstable;
        w_mismatch_nxt = r_mismatch;
        w_pass_nxt     = r_pass;
        w_start_sample = 1'b0;
        w_sample_en    = 1'b0;

        case (r_state)
            IDLE: begin
                w_gate_in_nxt = '0;
                if (start) begin
                    w_expected_nxt = expected;
                    w_row_nxt      = '0;
                    w_captured_nxt = '0;
                    w_unstable_nxt = '0;
                    w_state_nxt    = APPLY;
                end
            end
            APPLY: begin
                w_settle_nxt = SETTLE_W'(SETTLE_CYCLES - 1);
                w_state_nxt  = SETTLE;
            end
            SETTLE: begin
                if (r_settle == '0) begin
                    w_start_sample = 1'b1;
                    w_state_nxt    = SAMPLE;
                end else begin
                    w_settle_nxt = r_settle - SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                w_sample_en = 1'b1;
                if (!w_stable) begin
                    w_unstable_nxt[w_bit] = 1'b1;
                end
                if (w_last) begin
                    w_captured_nxt[w_bit] = w_value;
                    if (r_row == ROW_W'(NUM_ROWS - 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_row_nxt     = r_row + ROW_W'(1);
                        w_gate_in_nxt = r_row + ROW_W'(1);
                        w_state_nxt   = APPLY;
                    end
                end
            end
            DONE: begin
                w_gate_in_nxt = '0;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_gate_in_nxt = '0;
                w_state_nxt   = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = (w_state_nxt == DONE);
        if (w_state_nxt == DONE) begin
            w_mismatch_nxt = w_captured_nxt ^ r_expected;
            w_pass_nxt     = (w_captured_nxt == r_expected) && (w_unstable_nxt == '0);
        end
    end

    assign gate_in1 = r_gate_in[2];
    assign gate_in2 = r_gate_in[1];
    assign gate_in3 = r_gate_in[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign captured = r_captured;
    assign mismatch = r_mismatch;
    assign pass     = r_pass;
    assign unstable = r_unstable;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: two sequencers (default and fast timing) driving modelled gates.
`timescale 1ns/1ps
module tb_truth_table_sequencer;

    typedef struct {
        int         dut;
        logic [7:0] cap;
        logic [7:0] mis;
        logic [7:0] uns;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_v;
    logic [7:0] exp_v [2];
    logic [1:0] gi1_v, gi2_v, gi3_v;
    logic [1:0] gate_out_v;
    logic [1:0] busy_v, done_v, pass_v;
    logic [7:0] cap_v [2];
    logic [7:0] mis_v [2];
    logic [7:0] uns_v [2];

    logic [7:0] tt_v [2];
    logic       glitch;
    logic       mon_en;
    int         hold;
    logic [2:0] last_row0;
    logic [2:0] row0, row1;

    bit         m_act [2];
    int         m_cyc [2];
    exp_t       sb_q [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_done   = 0;

    always #5 clk = ~clk;

    truth_table_sequencer #(.SETTLE_CYCLES(4), .NUM_SAMPLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .expected(exp_v[0]),
        .gate_in1(gi1_v[0]), .gate_in2(gi2_v[0]), .gate_in3(gi3_v[0]),
        .gate_out(gate_out_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .captured(cap_v[0]), .mismatch(mis_v[0]), .pass(pass_v[0]), .unstable(uns_v[0])
    );

    truth_table_sequencer #(.SETTLE_CYCLES(1), .NUM_SAMPLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .expected(exp_v[1]),
        .gate_in1(gi1_v[1]), .gate_in2(gi2_v[1]), .gate_in3(gi3_v[1]),
        .gate_out(gate_out_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .captured(cap_v[1]), .mismatch(mis_v[1]), .pass(pass_v[1]), .unstable(uns_v[1])
    );

    // Gate models: out = tt[7-row]; dut0 can glitch on the second sample of row 011.
    assign row0 = {gi1_v[0], gi2_v[0], gi3_v[0]};
    assign row1 = {gi1_v[1], gi2_v[1], gi3_v[1]};
    assign gate_out_v[0] = tt_v[0][3'd7 - row0] ^ (glitch && (row0 == 3'd3) && (hold == 6));
    assign gate_out_v[1] = tt_v[1][3'd7 - row1];

    always @(negedge clk) begin
        if (row0 != last_row0) hold <= 0;
        else if (hold < 1000) hold <= hold + 1;
        last_row0 <= row0;
    end

    function automatic int per_row(input int d);
        return (d == 0) ? 7 : 3;
    endfunction

    function automatic int total(input int d);
        return 8 * per_row(d) + 1;
    endfunction

    function automatic int exp_row(input int d, input int k);
        if (k >= total(d) - 1 + 1) return 7;
        return (k - 1) / per_row(d);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Timing model: m_cyc is the cycle number after the start-accept edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] <= 1'b0;
                m_cyc[d] <= 0;
            end else if (!m_act[d]) begin
                if (start_v[d]) begin
                    m_act[d] <= 1'b1;
                    m_cyc[d] <= 1;
                end
            end else if (m_cyc[d] == total(d)) begin
                m_act[d] <= 1'b0;
                m_cyc[d] <= 0;
            end else begin
                m_cyc[d] <= m_cyc[d] + 1;
            end
        end
    end

    // Monitor: per-cycle handshake/row checks, scoreboard pop on every done pulse.
    always @(negedge clk) begin : mon
        logic [2:0] row;
        exp_t       e;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                row = {gi1_v[d], gi2_v[d], gi3_v[d]};
                if (m_act[d]) begin
                    chk($sformatf("busy%0d cyc%0d", d, m_cyc[d]), 32'(busy_v[d]), 32'd1);
                    chk($sformatf("gate_in%0d cyc%0d", d, m_cyc[d]), 32'(row), 32'(exp_row(d, m_cyc[d])));
                    chk($sformatf("done%0d cyc%0d", d, m_cyc[d]), 32'(done_v[d]), 32'(m_cyc[d] == total(d)));
                end else begin
                    chk($sformatf("idle_busy%0d", d), 32'(busy_v[d]), 32'd0);
                    chk($sformatf("idle_done%0d", d), 32'(done_v[d]), 32'd0);
                    chk($sformatf("idle_gate_in%0d", d), 32'(row), 32'd0);
                end
                if (done_v[d] === 1'b1) begin
                    n_done++;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected_done dut%0d actual=done required=no_done", d);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_dut", 32'(d), 32'(e.dut));
                        chk($sformatf("captured%0d", d), 32'(cap_v[d]), 32'(e.cap));
                        chk($sformatf("mismatch%0d", d), 32'(mis_v[d]), 32'(e.mis));
                        chk($sformatf("unstable%0d", d), 32'(uns_v[d]), 32'(e.uns));
                        chk($sformatf("pass%0d", d), 32'(pass_v[d]), 32'(e.pass));
                    end
                end
            end
        end
    end

    task automatic push_exp(input int d, input logic [7:0] e, input logic [7:0] cap,
                            input logic [7:0] uns, input logic ps);
        exp_t x;
        x.dut = d; x.cap = cap; x.mis = cap ^ e; x.uns = uns; x.pass = ps;
        sb_q.push_back(x);
    endtask

    task automatic sweep(input int d, input logic [7:0] e, input logic [7:0] cap,
                         input logic [7:0] uns, input logic ps);
        @(negedge clk);
        exp_v[d]   = e;
        start_v[d] = 1'b1;
        push_exp(d, e, cap, uns, ps);
        @(negedge clk);
        start_v[d] = 1'b0;
        exp_v[d]   = ~e;
    endtask

    task automatic wait_cyc(input int d, input int k);
        for (int i = 0; i < 400; i++) begin
            if (m_cyc[d] == k) return;
            @(negedge clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_cyc dut%0d actual=timeout required=cycle%0d", d, k);
    endtask

    task automatic wait_idle(input int d);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!m_act[d]) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_idle dut%0d actual=timeout required=idle", d);
    endtask

    task automatic chk_cleared(input int d, input string tag);
        chk({tag, "_busy"},     32'(busy_v[d]), 32'd0);
        chk({tag, "_done"},     32'(done_v[d]), 32'd0);
        chk({tag, "_captured"}, 32'(cap_v[d]),  32'd0);
        chk({tag, "_mismatch"}, 32'(mis_v[d]),  32'd0);
        chk({tag, "_unstable"}, 32'(uns_v[d]),  32'd0);
        chk({tag, "_pass"},     32'(pass_v[d]), 32'd0);
        chk({tag, "_gate_in"},  32'({gi1_v[d], gi2_v[d], gi3_v[d]}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start_v = '0; exp_v[0] = '0; exp_v[1] = '0;
        tt_v[0] = 8'hA3; tt_v[1] = 8'h00; glitch = 1'b0; mon_en = 1'b0;
        hold = 0; last_row0 = '0;
        repeat (3) @(negedge clk);
        chk_cleared(0, "rst0");
        chk_cleared(1, "rst1");
        rst = 1'b0;
        mon_en = 1'b1;

        // Gate 0xA3 matches expected.
        sweep(0, 8'hA3, 8'hA3, 8'h00, 1'b1);
        wait_idle(0);

        // Reset on cycle 20 aborts the sweep; results and pass cleared.
        sweep(0, 8'hA3, 8'hA3, 8'h00, 1'b1);
        wait_cyc(0, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        chk_cleared(0, "abort0");
        sweep(0, 8'hA3, 8'hA3, 8'h00, 1'b1);
        wait_idle(0);

        // Expected differs in the LSB.
        sweep(0, 8'hA2, 8'hA3, 8'h00, 1'b0);
        wait_idle(0);

        // Glitch on the second sample of row 011.
        glitch = 1'b1;
        sweep(0, 8'hA3, 8'hA3, 8'h10, 1'b0);
        wait_idle(0);
        glitch = 1'b0;

        // start pulses mid-sweep are ignored.
        sweep(0, 8'hA3, 8'hA3, 8'h00, 1'b1);
        wait_cyc(0, 5);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_cyc(0, 30);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle(0);

        // Fast timing, gate 0x00 against expected 0xFF.
        sweep(1, 8'hFF, 8'h00, 8'h00, 1'b0);
        wait_idle(1);

        // start held high re-triggers right after DONE.
        @(negedge clk);
        exp_v[1]   = 8'h00;
        start_v[1] = 1'b1;
        push_exp(1, 8'h00, 8'h00, 8'h00, 1'b1);
        push_exp(1, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        wait_cyc(1, 25);
        @(negedge clk);
        @(negedge clk);
        start_v[1] = 1'b0;
        wait_idle(1);

        repeat (3) @(negedge clk);
        chk("done_count", 32'(n_done), 32'd8);
        chk("sb_left", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
